// File: rtl/instr_decode_buffer.sv
// Two-entry elastic buffer between fetch and decode; head entry is split into MIPS fields.
// Optional stall counter output enabled by defining IDB_STALL_CNT_EN.
module instr_decode_buffer #(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [15:0]     imm16,
`ifdef IDB_STALL_CNT_EN
    output logic [15:0]     stall_cycles,
`endif
    output logic            is_rtype
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [31:0]     instr0_q;
    logic [31:0]     instr1_q;
    logic [PC_W-1:0] pc0_q;
    logic [PC_W-1:0] pc1_q;

    logic push;
    logic pop;

    assign push = in_valid & in_ready_q & ~flush;
    assign pop  = out_valid_q & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            instr0_q    <= '0;
            instr1_q    <= '0;
            pc0_q       <= '0;
            pc1_q       <= '0;
        end else if (flush) begin
            // Storage is left untouched so the field outputs keep the last head.
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        instr0_q    <= in_instr;
                        pc0_q       <= in_pc;
                        state_q     <= StOne;
                        out_valid_q <= 1'b1;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        instr0_q <= in_instr;
                        pc0_q    <= in_pc;
                    end else if (push) begin
                        instr1_q   <= in_instr;
                        pc1_q      <= in_pc;
                        state_q    <= StFull;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q     <= StEmpty;
                        out_valid_q <= 1'b0;
                    end
                end
                StFull: begin
                    if (pop) begin
                        instr0_q   <= instr1_q;
                        pc0_q      <= pc1_q;
                        state_q    <= StOne;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StEmpty;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef IDB_STALL_CNT_EN
    logic [15:0] stall_q;

    // Counts head-held cycles; only reset clears it, flush does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = instr0_q;
    assign out_pc    = pc0_q;
    assign opcode    = instr0_q[31:26];
    assign rs        = instr0_q[25:21];
    assign rt        = instr0_q[20:16];
    assign rd        = instr0_q[15:11];
    assign shamt     = instr0_q[10:6];
    assign funct     = instr0_q[5:0];
    assign imm16     = instr0_q[15:0];
    assign is_rtype  = (instr0_q[31:26] == 6'b000000);

endmodule

// File: tb/tb_instr_decode_buffer.sv
// Directed self-checking bench for instr_decode_buffer.
// Stall counter checks run only when IDB_STALL_CNT_EN is defined.
module tb_instr_decode_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        is_rtype;
`ifdef IDB_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int tests = 0;
    int fails = 0;

    instr_decode_buffer #(
        .PC_W(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .funct    (funct),
        .imm16    (imm16),
`ifdef IDB_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .is_rtype (is_rtype)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_is_rtype", 32'(is_rtype), 32'd1);

        // Single addi $t0,$zero,-1
        in_valid  = 1'b1;
        in_instr  = 32'h2008_FFFF;
        in_pc     = 32'h0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_opcode", 32'(opcode), 32'h08);
        chk("t1_rs", 32'(rs), 32'd0);
        chk("t1_rt", 32'(rt), 32'd8);
        chk("t1_imm16", 32'(imm16), 32'hFFFF);
        chk("t1_is_rtype", 32'(is_rtype), 32'd0);
        chk("t1_out_pc", out_pc, 32'h0);
        step();
        chk("t1_drained", 32'(out_valid), 32'd0);
        chk("t1_hold_instr", out_instr, 32'h2008_FFFF);

        // Fill to FULL with decode stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h012A_4020;
        in_pc     = 32'h4;
        step();
        chk("t2_one_in_ready", 32'(in_ready), 32'd1);
        in_instr = 32'h8D09_0004;
        in_pc    = 32'h8;
        step();
        in_valid = 1'b0;
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        chk("t2_full_out_valid", 32'(out_valid), 32'd1);
        chk("t2_full_head", out_instr, 32'h012A_4020);
        in_valid = 1'b1;
        in_instr = 32'hDEAD_BEEF;
        step();
        in_valid = 1'b0;
        chk("t2_full_no_overwrite", out_instr, 32'h012A_4020);
        chk("t2_full_still_blocked", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        chk("t2_head_rd", 32'(rd), 32'd8);
        chk("t2_head_funct", 32'(funct), 32'h20);
        chk("t2_head_rs", 32'(rs), 32'd9);
        chk("t2_head_rt", 32'(rt), 32'd10);
        chk("t2_head_is_rtype", 32'(is_rtype), 32'd1);
        chk("t2_head_pc", out_pc, 32'h4);
        step();
        chk("t2_second_instr", out_instr, 32'h8D09_0004);
        chk("t2_second_pc", out_pc, 32'h8);
        chk("t2_second_opcode", 32'(opcode), 32'h23);
        chk("t2_in_ready_after_pop", 32'(in_ready), 32'd1);
        step();
        chk("t2_empty", 32'(out_valid), 32'd0);

        // Streaming at one instruction per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h2400_0100 + 32'(i);
            in_pc    = 32'h100 + 32'(i * 4);
            step();
            chk("t3_stream_valid", 32'(out_valid), 32'd1);
            chk("t3_stream_instr", out_instr, 32'h2400_0100 + 32'(i));
            chk("t3_stream_pc", out_pc, 32'h100 + 32'(i * 4));
        end
        in_valid = 1'b0;
        step();
        chk("t3_stream_end", 32'(out_valid), 32'd0);

        // Flush at FULL with a concurrent offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hAAAA_0001;
        in_pc     = 32'h200;
        step();
        in_instr = 32'hBBBB_0002;
        in_pc    = 32'h204;
        step();
        chk("t4_full", 32'(in_ready), 32'd0);
        flush    = 1'b1;
        in_instr = 32'h1000_0003;
        in_pc    = 32'h208;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_flush_out_valid", 32'(out_valid), 32'd0);
        chk("t4_flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_no_ghost", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1;
        in_instr = 32'h3C01_0001;
        in_pc    = 32'h300;
        out_ready = 1'b0;
        step();
        chk("t4_after_flush_head", out_instr, 32'h3C01_0001);
        chk("t4_after_flush_pc", out_pc, 32'h300);

        // Flush at ONE with an acceptable push offered: push must be lost
        in_instr = 32'h1111_2222;
        in_pc    = 32'h304;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_flush_one_valid", 32'(out_valid), 32'd0);
        step();
        chk("t5_flush_one_stays", 32'(out_valid), 32'd0);
        chk("t5_storage_kept", out_instr, 32'h3C01_0001);

        // Reset mid-operation zeros storage
        in_valid = 1'b1;
        in_instr = 32'h5555_AAAA;
        in_pc    = 32'h400;
        step();
        in_valid = 1'b0;
        chk("t6_loaded", out_instr, 32'h5555_AAAA);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_instr", out_instr, 32'h0);
        chk("t6_rst_pc", out_pc, 32'h0);

`ifdef IDB_STALL_CNT_EN
        chk("t7_stall_rst", 32'(stall_cycles), 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h2009_0005;
        in_pc     = 32'h500;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b1;
        step();
        chk("t7_stall_five", 32'(stall_cycles), 32'd5);
        chk("t7_popped", 32'(out_valid), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t7_stall_flush", 32'(stall_cycles), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t7_stall_reset", 32'(stall_cycles), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
